int_fp_adder: RTL and testbench
===============================

# int_fp_adder

Dual-mode 16-bit adder for the INT/FP MAC datapath. A `mode` input selects between two operations on the same operand ports: a 16-bit two's-complement integer add or an IEEE 754 binary16 (half-precision) floating-point add. The result is registered, with one-cycle latency and a throughput of one operation per cycle. The block is the accumulate stage that sits behind the multiplier in the MAC.

## Interface
- No parameters. Width is fixed at 16 bits.
- `clk` input, 1 bit: single clock. All state updates on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `mode` input, 1 bit: operation select. 0 selects INT16 add; 1 selects FP16 add.
- `input1` input, 16 bits: operand A.
- `input2` input, 16 bits: operand B.
- `result` output, 16 bits: registered sum.

## Operation
- **INT mode (`mode`=0):**
  - `result` = (`input1` + `input2`) mod 2^16, treating the operands as two's complement.
  - Overflow wraps by default; see Configuration for the saturating option.
- **FP mode (`mode`=1):** binary16 operands, with 1 sign bit, 5 exponent bits (bias 15) and 10 mantissa bits. Processing steps:
  - Unpack both operands. Subnormals (exponent 0) use an implicit leading 0 and an effective exponent of 1.
  - Swap operands so the larger magnitude comes first.
  - Align the smaller operand by right-shifting it, keeping guard, round and sticky bits. A shift of 13 or more reduces it to sticky only.
  - Add the mantissas if the signs match, otherwise subtract them.
  - Normalize the result with a leading-zero count, or a 1-bit right shift on carry-out.
  - Round to nearest, ties to even. Rounding carry may bump the exponent.
- **FP special cases:**
  - Any NaN input gives the canonical NaN 16'h7E00.
  - +Inf + −Inf gives 16'h7E00.
  - Inf + finite gives that Inf.
  - A finite result that overflows past the maximum exponent gives ±Inf (16'h7C00 / 16'hFC00).
  - An exact-zero result from operands of opposite sign gives +0 (16'h0000).
  - −0 + −0 gives −0 (16'h8000).
  - Subnormal results are produced exactly (gradual underflow). There is no flush-to-zero.
- No exception flags are produced.

## Timing
- `result` is the only state element.
- While `rst`=1, `result` = 16'h0000 immediately, regardless of `clk`.
- On each rising `clk` with `rst`=0, `result` is loaded with f(`mode`, `input1`, `input2`), using the values sampled at that edge.
- Latency is 1 cycle and throughput is 1 per cycle.
- There is no handshake and no valid signal. The output holds its value until the next edge.
- A change of `mode` between cycles takes effect on the next edge. There is no pipeline hazard.
- Reset asserted mid-stream discards the pending result. The first post-reset result appears on the first rising edge after `rst` deasserts.
- All arithmetic is combinational between the input ports and the `result` register. The design must close timing in a single cycle.

## Configuration
- Macro: `INT_FP_ADD_SAT_EN`.
- **Defined:** INT mode saturates.
  - Positive overflow gives 16'h7FFF.
  - Negative overflow gives 16'h8000.
  - Overflow is detected when the operand signs are equal and the sum sign differs.
- **Undefined (default):** INT mode wraps modulo 2^16.
- FP mode is unaffected in both cases.

## Test plan
- **Reset:** assert `rst` with the clock running → `result`=16'h0000 immediately. Deassert, then apply `mode`=1, `input1`=16'h3C00, `input2`=16'h3C00 → 16'h4000 (1.0+1.0=2.0) one cycle later.
- **INT add:**
  - `mode`=0, 16'h0005 + 16'hFFFD → 16'h0002.
  - 16'h7FFF + 16'h0001 → 16'h8000 (wrap). With `INT_FP_ADD_SAT_EN` defined, the same inputs give 16'h7FFF.
  - 16'h8000 + 16'hFFFF → 16'h8000 with the macro defined.
- **FP cancellation and rounding:**
  - 16'h3C00 + 16'hBC00 → 16'h0000.
  - 16'h3C00 + 16'h1000 (1 + 2^-11, a tie) → 16'h3C00 (ties to even).
  - 16'h3C01 + 16'h1000 → 16'h3C02.
- **FP overflow and specials:**
  - 16'h7BFF + 16'h7BFF → 16'h7C00.
  - 16'h7C00 + 16'hFC00 → 16'h7E00.
  - 16'h7E00 + 16'h3C00 → 16'h7E00.
  - 16'h8000 + 16'h8000 → 16'h8000.
- **FP subnormals:**
  - 16'h0001 + 16'h0001 → 16'h0002.
  - 16'h03FF + 16'h0001 → 16'h0400 (subnormal to normal transition).
  - 16'h0400 + 16'h8001 → 16'h03FF.
- **Back-to-back:** alternate `mode` every cycle with the above vectors → each result appears exactly one cycle after its inputs, with no cross-cycle corruption.

Source files
------------

// File: rtl/int_fp_adder.sv
// Dual-mode 16-bit adder: INT16 two's-complement add or IEEE 754 binary16 add, one registered result.
// Optional feature: define INT_FP_ADD_SAT_EN to make INT mode saturate instead of wrap.
module int_fp_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [15:0] input1,
    input  logic [15:0] input2,
    output logic [15:0] result
);

    logic [15:0] result_d, result_q;
    logic [15:0] int_sum, int_res, fp_res;

    always_comb begin
        int_sum = input1 + input2;
`ifdef INT_FP_ADD_SAT_EN
        int_res = int_sum;
        if ((input1[15] == input2[15]) && (int_sum[15] != input1[15]))
            int_res = input1[15] ? 16'h8000 : 16'h7FFF;
`else
        int_res = int_sum;
`endif
    end

    logic        a_nan, b_nan, a_inf, b_inf;
    logic        swap;
    logic [15:0] op_l, op_s;
    logic [4:0]  e_l, e_s, d;
    logic [3:0]  d_cap;
    logic [10:0] m_l, m_s;
    logic [27:0] shifted;
    logic [13:0] m_l_ext, m_s_al;
    logic        eff_sub;
    logic [14:0] sum;
    logic [3:0]  lz, sh;
    logic [13:0] norm;
    logic [5:0]  exp_eff, exp_fld;
    logic        round_up;
    logic [15:0] packed_r;

    always_comb begin
        a_nan = (input1[14:10] == 5'h1F) && (input1[9:0] != 10'h000);
        b_nan = (input2[14:10] == 5'h1F) && (input2[9:0] != 10'h000);
        a_inf = (input1[14:10] == 5'h1F) && (input1[9:0] == 10'h000);
        b_inf = (input2[14:10] == 5'h1F) && (input2[9:0] == 10'h000);

        swap = input2[14:0] > input1[14:0];
        op_l = swap ? input2 : input1;
        op_s = swap ? input1 : input2;

        // Subnormals share the effective exponent 1 with a hidden bit of 0
        e_l = (op_l[14:10] == 5'h00) ? 5'd1 : op_l[14:10];
        e_s = (op_s[14:10] == 5'h00) ? 5'd1 : op_s[14:10];
        m_l = {(op_l[14:10] != 5'h00), op_l[9:0]};
        m_s = {(op_s[14:10] != 5'h00), op_s[9:0]};

        d       = e_l - e_s;
        d_cap   = (d > 5'd15) ? 4'd15 : d[3:0];
        shifted = {m_s, 3'b000, 14'b0} >> d_cap;
        m_l_ext = {m_l, 3'b000};
        m_s_al  = shifted[27:14] | {13'b0, (shifted[13:0] != 14'b0)};

        eff_sub = op_l[15] ^ op_s[15];
        sum = eff_sub ? ({1'b0, m_l_ext} - {1'b0, m_s_al})
                      : ({1'b0, m_l_ext} + {1'b0, m_s_al});

        lz = 4'd14;
        for (int unsigned i = 0; i < 14; i++)
            if (sum[i]) lz = 4'(13 - i);

        // Left shift stops at effective exponent 1, leaving a subnormal result
        sh = ({1'b0, lz} <= (e_l - 5'd1)) ? lz : 4'(e_l - 5'd1);

        if (sum[14]) begin
            norm    = sum[14:1] | {13'b0, sum[0]};
            exp_eff = {1'b0, e_l} + 6'd1;
        end else begin
            norm    = sum[13:0] << sh;
            exp_eff = {1'b0, e_l} - {2'b0, sh};
        end

        exp_fld  = norm[13] ? exp_eff : 6'd0;
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        // Rounding carry ripples straight into the exponent field
        packed_r = {exp_fld, norm[12:3]} + {15'b0, round_up};

        if (a_nan || b_nan)
            fp_res = 16'h7E00;
        else if (a_inf && b_inf && (input1[15] != input2[15]))
            fp_res = 16'h7E00;
        else if (a_inf)
            fp_res = input1;
        else if (b_inf)
            fp_res = input2;
        else if (sum == 15'b0)
            fp_res = (input1[15] & input2[15]) ? 16'h8000 : 16'h0000;
        else if (packed_r[15:10] >= 6'd31)
            fp_res = {op_l[15], 15'h7C00};
        else
            fp_res = {op_l[15], packed_r[14:0]};
    end

    assign result_d = mode ? fp_res : int_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) result_q <= '0;
        else     result_q <= result_d;
    end

    assign result = result_q;

endmodule

// File: tb/tb_int_fp_adder.sv
// Scoreboard bench for int_fp_adder: driver queues expected results, monitor checks one cycle later.
module tb_int_fp_adder;

    logic        clk;
    logic        rst;
    logic        mode;
    logic [15:0] input1, input2;
    logic [15:0] result;

    int_fp_adder dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .input1 (input1),
        .input2 (input2),
        .result (result)
    );

    typedef struct {
        logic        m;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] e_wrap;
        logic [15:0] e_sat;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_q[$];
    string       name_q[$];
    logic        issue;
    logic        pend;
    int          passed;
    int          total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, req);
    endtask

    task automatic send(input logic m, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e, input string nm);
        @(negedge clk);
        mode   = m;
        input1 = a;
        input2 = b;
        issue  = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle();
        @(negedge clk);
        issue = 1'b0;
    endtask

    function automatic vec_t mk(logic m, logic [15:0] a, logic [15:0] b,
                                logic [15:0] ew, logic [15:0] es);
        vec_t v;
        v.m = m; v.a = a; v.b = b; v.e_wrap = ew; v.e_sat = es;
        return v;
    endfunction

    always begin
        @(posedge clk);
        pend = issue && !rst;
        #1;
        if (pend) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL scoreboard: got %h with no expected entry", result);
            end else begin
                check(name_q.pop_front(), result, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        passed = 0;
        total  = 0;
        issue  = 1'b0;
        mode   = 1'b0;
        input1 = '0;
        input2 = '0;
        rst    = 1'b0;

        vecs.push_back(mk(1'b1, 16'h3C00, 16'h3C00, 16'h4000, 16'h4000));
        vecs.push_back(mk(1'b0, 16'h0005, 16'hFFFD, 16'h0002, 16'h0002));
        vecs.push_back(mk(1'b1, 16'h3C00, 16'hBC00, 16'h0000, 16'h0000));
        vecs.push_back(mk(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF));
        vecs.push_back(mk(1'b1, 16'h3C00, 16'h1000, 16'h3C00, 16'h3C00));
        vecs.push_back(mk(1'b0, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000));
        vecs.push_back(mk(1'b1, 16'h3C01, 16'h1000, 16'h3C02, 16'h3C02));
        vecs.push_back(mk(1'b0, 16'h1234, 16'h1111, 16'h2345, 16'h2345));
        vecs.push_back(mk(1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00, 16'h7C00));
        vecs.push_back(mk(1'b0, 16'h3C00, 16'h3C00, 16'h7800, 16'h7800));
        vecs.push_back(mk(1'b1, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7E00));
        vecs.push_back(mk(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000));
        vecs.push_back(mk(1'b1, 16'h7E00, 16'h3C00, 16'h7E00, 16'h7E00));
        vecs.push_back(mk(1'b0, 16'h8000, 16'h8000, 16'h0000, 16'h8000));
        vecs.push_back(mk(1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000));
        vecs.push_back(mk(1'b0, 16'h0064, 16'hFF9C, 16'h0000, 16'h0000));
        vecs.push_back(mk(1'b1, 16'h0001, 16'h0001, 16'h0002, 16'h0002));
        vecs.push_back(mk(1'b1, 16'h03FF, 16'h0001, 16'h0400, 16'h0400));
        vecs.push_back(mk(1'b1, 16'h0400, 16'h8001, 16'h03FF, 16'h03FF));
        vecs.push_back(mk(1'b1, 16'h3C00, 16'hC000, 16'hBC00, 16'hBC00));
        vecs.push_back(mk(1'b1, 16'h7C00, 16'h3C00, 16'h7C00, 16'h7C00));
        vecs.push_back(mk(1'b0, 16'h4000, 16'h4000, 16'h8000, 16'h7FFF));

        #2 rst = 1'b1;
        #1 check("reset_async", result, 16'h0000);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", result, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
`ifdef INT_FP_ADD_SAT_EN
            send(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].e_sat, $sformatf("vec%0d", i));
`else
            send(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].e_wrap, $sformatf("vec%0d", i));
`endif
        end
        idle();
        idle();

        @(negedge clk);
        #3 rst = 1'b1;
        #1 check("midstream_rst", result, 16'h0000);
        @(negedge clk);
        mode   = 1'b0;
        input1 = 16'h1111;
        input2 = 16'h1111;
        @(posedge clk);
        #1 check("rst_over_edge", result, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        send(1'b1, 16'h3C00, 16'h3C00, 16'h4000, "post_rst");
        idle();
        idle();

        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
